ufm_write: RTL and testbench

// - Saves the live config (psRef, relays, sgRefFreq, sgDP0..7) to MAX10 UFM so it is restored at next power-up.
// - Disables write protect, erases the UFM sector, writes 6 packed 32-bit words, then re-protects the sector.
// - Uses the flash CSR port (erase/protect/status) and the data port (writes).
// - Word layout matches the UFM power-up load path.

---
 rtl/ufm_write.sv | 236 +++++++++++++++++++++++
 tb/tb_ufm_write.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_write.sv
// ufm_write: saves the live configuration into a MAX10 UFM sector (unprotect, erase, write 6 words, re-protect).
// Optional UFM_VERIFY_EN: read the six words back and flag an error on any mismatch.
`default_nettype none
`timescale 1ns/1ps

module ufm_write #(
    parameter logic [3:0]  WRITE_STATE  = 4'h5,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [2:0]  SECTOR       = 3'd1,
    parameter logic [19:0] POLL_TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  controlstate,
    input  logic [9:0]  psRef,
    input  logic        relay1,
    input  logic        relay2,
    input  logic [23:0] sgRefFreq,
    input  logic [11:0] sgDP0,
    input  logic [11:0] sgDP1,
    input  logic [11:0] sgDP2,
    input  logic [11:0] sgDP3,
    input  logic [11:0] sgDP4,
    input  logic [11:0] sgDP5,
    input  logic [11:0] sgDP6,
    input  logic [11:0] sgDP7,
    output logic        ufmwrite,
    output logic [15:0] write_addr,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    output logic        csr_write,
    output logic        csr_read,
    output logic        csr_addr,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
`ifdef UFM_VERIFY_EN
    output logic        ufmread,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
`endif
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [4:0]  WP_OPEN     = ~(5'b00001 << SECTOR);
    localparam logic [31:0] CTRL_UNPROT = {4'hF, WP_OPEN, 3'b111, 20'hFFFFF};
    localparam logic [31:0] CTRL_ERASE  = {4'hF, WP_OPEN, SECTOR, 20'hFFFFF};
    localparam logic [31:0] CTRL_PROT   = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNPROT,
        S_ERASE,
        S_EPOLL,
        S_WRITE,
        S_WPOLL,
`ifdef UFM_VERIFY_EN
        S_VERIFY,
`endif
        S_PROT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        prev_cs_q;
    logic [5:0][31:0]  words_q;
    logic [2:0]        word_cnt_q, word_cnt_d;
    logic [19:0]       poll_cnt_q, poll_cnt_d;
    logic              phase_q, phase_d;
    logic              error_q, error_d;
    logic              capture;
    logic              start;
    logic              status_ok;
    logic              w_unused_status;

    assign start           = (controlstate == WRITE_STATE) && (prev_cs_q != WRITE_STATE);
    assign status_ok       = (state_q == S_EPOLL) ? csr_readdata[4] : csr_readdata[3];
    assign w_unused_status = &{1'b0, csr_readdata[31:5], csr_readdata[2]};
    assign error           = error_q;

    // Edge detector resets to WRITE_STATE so a level held through reset does not trigger a save.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prev_cs_q  <= WRITE_STATE;
            words_q    <= '0;
            word_cnt_q <= '0;
            poll_cnt_q <= '0;
            phase_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_cs_q  <= controlstate;
            word_cnt_q <= word_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            phase_q    <= phase_d;
            error_q    <= error_d;
            if (capture) begin
                words_q[0] <= {20'b0, relay2, relay1, psRef};
                words_q[1] <= {8'b0, sgRefFreq};
                words_q[2] <= {8'b0, sgDP1, sgDP0};
                words_q[3] <= {8'b0, sgDP3, sgDP2};
                words_q[4] <= {8'b0, sgDP5, sgDP4};
                words_q[5] <= {8'b0, sgDP7, sgDP6};
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        phase_d       = phase_q;
        error_d       = error_q;
        capture       = 1'b0;
        ufmwrite      = 1'b0;
        write_addr    = 16'h0000;
        writedata     = 32'h0000_0000;
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        csr_addr      = 1'b0;
        csr_writedata = 32'h0000_0000;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
`ifdef UFM_VERIFY_EN
        ufmread       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_UNPROT;
                    capture    = 1'b1;
                    error_d    = 1'b0;
                    word_cnt_d = 3'd0;
                    poll_cnt_d = 20'd0;
                    phase_d    = 1'b0;
                end
            end
            S_UNPROT: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = CTRL_UNPROT;
                state_d       = S_ERASE;
            end
            S_ERASE: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = CTRL_ERASE;
                state_d       = S_EPOLL;
            end
            // Phase 0 issues the status read, phase 1 consumes the returned word.
            S_EPOLL, S_WPOLL: begin
                csr_read = ~phase_q;
                phase_d  = ~phase_q;
                if (phase_q) begin
                    if (csr_readdata[1:0] == 2'b00) begin
                        poll_cnt_d = 20'd0;
                        if (!status_ok) begin
                            state_d = S_ERROR;
                        end else if (state_q == S_EPOLL) begin
                            state_d = S_WRITE;
                        end else if (word_cnt_q != 3'd5) begin
                            word_cnt_d = word_cnt_q + 3'd1;
                            state_d    = S_WRITE;
                        end else begin
`ifdef UFM_VERIFY_EN
                            word_cnt_d = 3'd0;
                            state_d    = S_VERIFY;
`else
                            state_d    = S_PROT;
`endif
                        end
                    end else if (poll_cnt_q == POLL_TIMEOUT - 20'd1) begin
                        poll_cnt_d = 20'd0;
                        state_d    = S_ERROR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 20'd1;
                    end
                end
            end
            S_WRITE: begin
                ufmwrite   = 1'b1;
                write_addr = BASE_ADDR + {13'b0, word_cnt_q};
                writedata  = words_q[word_cnt_q];
                if (!waitrequest) begin
                    state_d = S_WPOLL;
                end
            end
`ifdef UFM_VERIFY_EN
            S_VERIFY: begin
                write_addr = BASE_ADDR + {13'b0, word_cnt_q};
                if (!phase_q) begin
                    ufmread = 1'b1;
                    if (!waitrequest) begin
                        phase_d = 1'b1;
                    end
                end else if (readdatavalid) begin
                    phase_d = 1'b0;
                    if (readdata != words_q[word_cnt_q]) begin
                        state_d = S_ERROR;
                    end else if (word_cnt_q == 3'd5) begin
                        state_d = S_PROT;
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                    end
                end
            end
`endif
            S_PROT: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = CTRL_PROT;
                state_d       = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                csr_write     = 1'b1;
                csr_addr      = 1'b1;
                csr_writedata = CTRL_PROT;
                error_d       = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ufm_write.sv
// tb_ufm_write: scoreboard bench for ufm_write against a small flash CSR/data-port model.
`default_nettype none
`timescale 1ns/1ps

module tb_ufm_write;

    localparam logic [3:0]  WS          = 4'h5;
    localparam int          LIMIT       = 400;
    localparam logic [31:0] CTRL_UNPROT = 32'hFEFF_FFFF;
    localparam logic [31:0] CTRL_ERASE  = 32'hFE9F_FFFF;
    localparam logic [31:0] CTRL_PROT   = 32'hFFFF_FFFF;
    localparam logic [31:0] ST_GOOD     = 32'h0000_0018;
`ifdef UFM_VERIFY_EN
    localparam int VER_EXTRA = 12;
`else
    localparam int VER_EXTRA = 0;
`endif
    localparam int EXP_LAT = 23 + VER_EXTRA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  controlstate;
    logic [9:0]  psRef;
    logic        relay1, relay2;
    logic [23:0] sgRefFreq;
    logic [11:0] dp [8];
    logic        ufmwrite;
    logic [15:0] write_addr;
    logic [31:0] writedata;
    logic        waitrequest;
    logic        csr_write, csr_read, csr_addr;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata = 32'h0;
    logic        busy, done, error;
`ifdef UFM_VERIFY_EN
    logic        ufmread;
    logic [31:0] readdata = 32'h0;
    logic        readdatavalid = 1'b0;
    logic [31:0] mem [8];
`endif

    logic [31:0] status_word;
    logic        stall_en;
    logic        corrupt;
    logic [3:0]  stall_cnt = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;
    int w3_cnt   = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    ufm_write #(
        .WRITE_STATE (WS),
        .BASE_ADDR   (16'h0000),
        .SECTOR      (3'd1),
        .POLL_TIMEOUT(20'd16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .controlstate (controlstate),
        .psRef        (psRef),
        .relay1       (relay1),
        .relay2       (relay2),
        .sgRefFreq    (sgRefFreq),
        .sgDP0        (dp[0]),
        .sgDP1        (dp[1]),
        .sgDP2        (dp[2]),
        .sgDP3        (dp[3]),
        .sgDP4        (dp[4]),
        .sgDP5        (dp[5]),
        .sgDP6        (dp[6]),
        .sgDP7        (dp[7]),
        .ufmwrite     (ufmwrite),
        .write_addr   (write_addr),
        .writedata    (writedata),
        .waitrequest  (waitrequest),
        .csr_write    (csr_write),
        .csr_read     (csr_read),
        .csr_addr     (csr_addr),
        .csr_writedata(csr_writedata),
        .csr_readdata (csr_readdata),
`ifdef UFM_VERIFY_EN
        .ufmread      (ufmread),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
`endif
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // Flash model: status returned the cycle after a CSR read; optional 3-cycle stall on word 3.
    assign waitrequest = stall_en && ufmwrite && (write_addr == 16'd3) && (stall_cnt < 4'd3);

    always @(posedge clk) begin
        if (csr_read) csr_readdata <= status_word;
        if (!stall_en) stall_cnt <= 4'd0;
        else if (waitrequest) stall_cnt <= stall_cnt + 4'd1;
`ifdef UFM_VERIFY_EN
        if (ufmwrite && !waitrequest)
            mem[write_addr[2:0]] <= writedata ^ {31'b0, corrupt && (write_addr == 16'd4)};
        readdatavalid <= ufmread && !waitrequest;
        readdata      <= mem[write_addr[2:0]];
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] txn(input logic [1:0] kind, input logic [15:0] a, input logic [31:0] d);
        return {14'b0, kind, a, d};
    endfunction

    function automatic logic [31:0] exp_word(input int n);
        if (n == 0) return {20'b0, relay2, relay1, psRef};
        if (n == 1) return {8'b0, sgRefFreq};
        return {8'b0, dp[2*n-3], dp[2*n-4]};
    endfunction

    task automatic push_csr(input logic [31:0] d);
        sb.push_back(txn(2'd1, 16'h0001, d));
    endtask

    task automatic push_full();
        push_csr(CTRL_UNPROT);
        push_csr(CTRL_ERASE);
        for (int n = 0; n < 6; n++) sb.push_back(txn(2'd2, n[15:0], exp_word(n)));
        push_csr(CTRL_PROT);
    endtask

    task automatic sb_take(input logic [63:0] got, input bit pop);
        if (sb.size() == 0) begin
            check("sb_extra", got, 64'h0);
        end else begin
            check("sb_txn", got, sb[0]);
            if (pop) void'(sb.pop_front());
        end
    endtask

    task automatic monitor_step();
        if (rst_n) begin
            if (csr_write) sb_take(txn(2'd1, {15'b0, csr_addr}, csr_writedata), 1'b1);
            if (ufmwrite) sb_take(txn(2'd2, write_addr, writedata), !waitrequest);
            if (csr_read) begin
                rd_cnt++;
                check("csr_rd_addr", {63'b0, csr_addr}, 64'h0);
            end
            if (done) done_cnt++;
            if (ufmwrite && write_addr == 16'd3) w3_cnt++;
        end
    endtask

    task automatic set_random();
        psRef     = 10'($urandom);
        relay1    = 1'($urandom);
        relay2    = 1'($urandom);
        sgRefFreq = 24'($urandom);
        for (int i = 0; i < 8; i++) dp[i] = 12'($urandom);
    endtask

    // Produces a fresh start edge, then runs until the DUT drops busy; lat_done is -1 if no done pulse.
    task automatic run_save(input bit toggle, output int lat_done);
        int k;
        lat_done = -1;
        @(negedge clk) controlstate = 4'h0;
        @(negedge clk) controlstate = WS;
        for (k = 1; k <= LIMIT; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check("busy_after_start", {63'b0, busy}, 64'h1);
                check("error_clr_on_start", {63'b0, error}, 64'h0);
            end
            if (toggle && k == 6) controlstate = 4'h0;
            if (toggle && k == 8) controlstate = WS;
            if (done && lat_done < 0) lat_done = k - 1;
            if (!busy) break;
        end
        check("save_finished", {63'b0, busy}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, d0, r0, w0;
        bit found;
        rst_n        = 1'b0;
        controlstate = 4'h0;
        status_word  = ST_GOOD;
        stall_en     = 1'b0;
        corrupt      = 1'b0;
        psRef        = '0;
        relay1       = 1'b0;
        relay2       = 1'b0;
        sgRefFreq    = '0;
        for (int i = 0; i < 8; i++) dp[i] = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {59'b0, ufmwrite, csr_write, csr_read, busy, done}, 64'h0);
        check("rst_error", {63'b0, error}, 64'h0);
        check("rst_addr", {48'b0, write_addr}, 64'h0);
        check("rst_wdata", {32'b0, writedata}, 64'h0);
        check("rst_csr_wdata", {32'b0, csr_writedata}, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // Reference save with fixed data words.
        psRef = 10'h155; relay1 = 1'b1; relay2 = 1'b0; sgRefFreq = 24'h123456;
        dp[0] = 12'hABC; dp[1] = 12'h123; dp[2] = 12'h456; dp[3] = 12'h789;
        dp[4] = 12'hDEF; dp[5] = 12'h0F0; dp[6] = 12'h5A5; dp[7] = 12'hA5A;
        push_csr(CTRL_UNPROT);
        push_csr(CTRL_ERASE);
        sb.push_back(txn(2'd2, 16'd0, 32'h0000_0555));
        sb.push_back(txn(2'd2, 16'd1, 32'h0012_3456));
        sb.push_back(txn(2'd2, 16'd2, 32'h0012_3ABC));
        sb.push_back(txn(2'd2, 16'd3, 32'h0078_9456));
        sb.push_back(txn(2'd2, 16'd4, 32'h000F_0DEF));
        sb.push_back(txn(2'd2, 16'd5, 32'h00A5_A5A5));
        push_csr(CTRL_PROT);
        d0 = done_cnt;
        run_save(1'b0, lat);
        check("t1_latency", 64'(lat), 64'(EXP_LAT));
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check("t1_error", {63'b0, error}, 64'h0);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Stall on W3 plus a controlstate bounce mid-save.
        set_random();
        stall_en = 1'b1;
        push_full();
        d0 = done_cnt; w0 = w3_cnt;
        run_save(1'b1, lat);
        stall_en = 1'b0;
        check("t2_latency", 64'(lat), 64'(EXP_LAT + 3));
        check("t2_w3_hold", 64'(w3_cnt - w0), 64'd4);
        check("t2_done_once", 64'(done_cnt - d0), 64'd1);
        check("t2_error", {63'b0, error}, 64'h0);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Erase reports failure: no data writes, re-protect, error.
        set_random();
        status_word = 32'h0000_0008;
        push_csr(CTRL_UNPROT);
        push_csr(CTRL_ERASE);
        push_csr(CTRL_PROT);
        d0 = done_cnt; r0 = rd_cnt;
        run_save(1'b0, lat);
        check("t3_error", {63'b0, error}, 64'h1);
        check("t3_no_done", 64'(done_cnt - d0), 64'd0);
        check("t3_polls", 64'(rd_cnt - r0), 64'd1);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Status busy stuck: timeout after 16 polls.
        status_word = 32'h0000_0019;
        push_csr(CTRL_UNPROT);
        push_csr(CTRL_ERASE);
        push_csr(CTRL_PROT);
        d0 = done_cnt; r0 = rd_cnt;
        run_save(1'b0, lat);
        check("t4_error", {63'b0, error}, 64'h1);
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        check("t4_polls", 64'(rd_cnt - r0), 64'd16);
        check("t4_sb_empty", 64'(sb.size()), 64'd0);
        status_word = ST_GOOD;

        // Reset during the W2 write, then a full save again.
        set_random();
        push_full();
        @(negedge clk) controlstate = 4'h0;
        @(negedge clk) controlstate = WS;
        found = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (ufmwrite && write_addr == 16'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reached_w2", {63'b0, found}, 64'h1);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_outputs", {56'b0, ufmwrite, csr_write, csr_read, busy, done, error, |write_addr, |writedata},
              64'h0);
        check("t5_rst_csr_wdata", {32'b0, csr_writedata}, 64'h0);
        sb.delete();
        @(negedge clk) controlstate = 4'h0;
        @(negedge clk) rst_n = 1'b1;
        set_random();
        push_full();
        d0 = done_cnt;
        run_save(1'b0, lat);
        check("t5_latency", 64'(lat), 64'(EXP_LAT));
        check("t5_done_once", 64'(done_cnt - d0), 64'd1);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

`ifdef UFM_VERIFY_EN
        // Read-back mismatch on W4.
        set_random();
        corrupt = 1'b1;
        push_full();
        d0 = done_cnt;
        run_save(1'b0, lat);
        corrupt = 1'b0;
        check("t6_error", {63'b0, error}, 64'h1);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
